// File: rtl/efpga_prog_loader.sv
// Host bitstream framer: parses MAGIC/count/chain headers and drives prog_i/prog_shft one cycle after each payload handshake.
// data_en is gated until the load completes. Defining EFPGA_PROG_CHECKSUM_EN adds an XOR trailer check (CHK state).
module efpga_prog_loader #(
   parameter int         NUM_CHAINS = 7,
   parameter int         CNT_W      = 16,
   parameter logic [7:0] MAGIC      = 8'h5A
) (
   input  logic                  clk,
   input  logic                  res,
   input  logic                  start,
   input  logic [31:0]           s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [31:0]           prog_i,
   output logic [NUM_CHAINS-1:0] prog_shft,
   input  logic                  user_data_en,
   output logic                  data_en,
   output logic                  cfg_busy,
   output logic                  cfg_done,
   output logic                  cfg_err
);

`ifdef EFPGA_PROG_CHECKSUM_EN
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR  = 3'd1,
      S_PAY  = 3'd2,
      S_CHK  = 3'd3,
      S_DONE = 3'd4,
      S_ERR  = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR  = 3'd1,
      S_PAY  = 3'd2,
      S_DONE = 3'd4,
      S_ERR  = 3'd5
   } state_t;
`endif

   localparam logic [NUM_CHAINS-1:0] ONE = {{(NUM_CHAINS-1){1'b0}}, 1'b1};

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       chain;
   logic             xfer;
   logic [CNT_W-1:0] hdr_cnt;
   logic [2:0]       hdr_chain;
   logic             hdr_bad;
`ifdef EFPGA_PROG_CHECKSUM_EN
   logic [31:0]      csum;
`endif

   assign xfer      = s_valid & s_ready;
   assign hdr_cnt   = s_data[8 +: CNT_W];
   assign hdr_chain = s_data[2:0];
   assign hdr_bad   = (s_data[31:24] != MAGIC) || (s_data[7:3] != 5'd0) ||
                      (32'(hdr_chain) >= NUM_CHAINS);
   assign data_en   = user_data_en & cfg_done;

   // s_ready/cfg_busy are written alongside every state change so they stay a registered state decode.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state     <= S_IDLE;
         prog_i    <= '0;
         prog_shft <= '0;
         s_ready   <= 1'b0;
         cfg_busy  <= 1'b0;
         cfg_done  <= 1'b0;
         cfg_err   <= 1'b0;
         cnt       <= '0;
         chain     <= '0;
`ifdef EFPGA_PROG_CHECKSUM_EN
         csum      <= '0;
`endif
      end else begin
         prog_shft <= '0;
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state    <= S_HDR;
                  s_ready  <= 1'b1;
                  cfg_busy <= 1'b1;
                  cfg_done <= 1'b0;
                  cfg_err  <= 1'b0;
`ifdef EFPGA_PROG_CHECKSUM_EN
                  csum     <= '0;
`endif
               end
            end
            S_HDR: begin
               if (xfer) begin
                  if (hdr_bad) begin
                     state    <= S_ERR;
                     s_ready  <= 1'b0;
                     cfg_busy <= 1'b0;
                     cfg_err  <= 1'b1;
                  end else if (hdr_cnt == '0) begin
`ifdef EFPGA_PROG_CHECKSUM_EN
                     state    <= S_CHK;
`else
                     state    <= S_DONE;
                     s_ready  <= 1'b0;
                     cfg_busy <= 1'b0;
                     cfg_done <= 1'b1;
`endif
                  end else begin
                     chain <= hdr_chain;
                     cnt   <= hdr_cnt;
                     state <= S_PAY;
                  end
               end
            end
            S_PAY: begin
               if (xfer) begin
                  prog_i    <= s_data;
                  prog_shft <= ONE << chain;
                  cnt       <= cnt - CNT_W'(1);
`ifdef EFPGA_PROG_CHECKSUM_EN
                  csum      <= csum ^ s_data;
`endif
                  if (cnt == CNT_W'(1)) begin
                     state <= S_HDR;
                  end
               end
            end
`ifdef EFPGA_PROG_CHECKSUM_EN
            S_CHK: begin
               if (xfer) begin
                  s_ready  <= 1'b0;
                  cfg_busy <= 1'b0;
                  if (s_data == csum) begin
                     state    <= S_DONE;
                     cfg_done <= 1'b1;
                  end else begin
                     state   <= S_ERR;
                     cfg_err <= 1'b1;
                  end
               end
            end
`endif
            default: begin
               state    <= S_IDLE;
               s_ready  <= 1'b0;
               cfg_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_efpga_prog_loader.sv
// Randomized self-checking bench for efpga_prog_loader against a frame-level stream model.
module tb_efpga_prog_loader;
   localparam int NC = 7;

   logic          clk = 1'b0;
   logic          res;
   logic          start;
   logic [31:0]   s_data;
   logic          s_valid;
   logic          s_ready;
   logic [31:0]   prog_i;
   logic [NC-1:0] prog_shft;
   logic          user_data_en;
   logic          data_en;
   logic          cfg_busy;
   logic          cfg_done;
   logic          cfg_err;

   int errors = 0;
   int checks = 0;

   // Expected word stream: word, payload flag, target chain.
   logic [31:0] wq[$];
   bit          pq[$];
   int          cq[$];
   bit          exp_err;
   bit          closed;
   int          cur_c;
   logic [31:0] xr;
   logic [31:0] exp_pi = 32'd0;

   efpga_prog_loader #(.NUM_CHAINS(NC), .CNT_W(16), .MAGIC(8'h5A)) dut (
      .clk(clk), .res(res), .start(start),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .prog_i(prog_i), .prog_shft(prog_shft),
      .user_data_en(user_data_en), .data_en(data_en),
      .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic new_stream();
      wq.delete(); pq.delete(); cq.delete();
      exp_err = 1'b0; closed = 1'b0; cur_c = 0; xr = 32'd0;
   endtask

   task automatic add_hdr(input logic [31:0] h, input bit flip);
      if (closed) return;
      wq.push_back(h); pq.push_back(1'b0); cq.push_back(0);
      if (h[31:24] != 8'h5A || h[7:3] != 5'd0 || int'(h[2:0]) >= NC) begin
         exp_err = 1'b1; closed = 1'b1;
      end else if (h[23:8] == 16'd0) begin
         closed = 1'b1;
`ifdef EFPGA_PROG_CHECKSUM_EN
         wq.push_back(flip ? (xr ^ 32'd1) : xr); pq.push_back(1'b0); cq.push_back(0);
         exp_err = flip;
`endif
      end else begin
         cur_c = int'(h[2:0]);
      end
   endtask

   task automatic add_word(input logic [31:0] w);
      if (closed) return;
      wq.push_back(w); pq.push_back(1'b1); cq.push_back(cur_c);
      xr = xr ^ w;
   endtask

   task automatic add_frame(input int c, input int n);
      add_hdr({8'h5A, 16'(n), 5'd0, 3'(c)}, 1'b0);
      for (int i = 0; i < n; i++) add_word($urandom);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_prog_i"}, prog_i, exp_pi);
      check({tag, "_shft"}, 32'(prog_shft), 32'd0);
      check({tag, "_ready"}, 32'(s_ready), 32'd0);
      check({tag, "_busy"}, 32'(cfg_busy), 32'd0);
      check({tag, "_done"}, 32'(cfg_done), 32'd0);
      check({tag, "_err"}, 32'(cfg_err), 32'd0);
      check({tag, "_data_en"}, 32'(data_en), 32'd0);
   endtask

   task automatic do_start();
      s_valid = 1'b0; start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      check("start_busy", 32'(cfg_busy), 32'd1);
      check("start_ready", 32'(s_ready), 32'd1);
      check("start_done", 32'(cfg_done), 32'd0);
      check("start_err", 32'(cfg_err), 32'd0);
   endtask

   task automatic run_stream(input int vprob, input int max_acc);
      int  k = 0;
      int  cyc = 0;
      int  target;
      bit  v, r;
      target = (wq.size() < max_acc) ? wq.size() : max_acc;
      while (k < target && cyc < 4000) begin
         v = ($urandom_range(0, 99) < vprob);
         s_valid = v;
         s_data = v ? wq[k] : $urandom;
         start = ($urandom_range(0, 19) == 0);
         user_data_en = 1'($urandom);
         r = s_ready;
         @(posedge clk); @(negedge clk);
         cyc++;
         start = 1'b0;
         if (v && r) begin
            if (pq[k]) exp_pi = wq[k];
            check("strobe", 32'(prog_shft), pq[k] ? (32'd1 << cq[k]) : 32'd0);
            k++;
         end else begin
            check("gap_strobe", 32'(prog_shft), 32'd0);
         end
         check("prog_i", prog_i, exp_pi);
         check("done_flag", 32'(cfg_done), 32'(k == wq.size() && !exp_err));
         check("err_flag", 32'(cfg_err), 32'(k == wq.size() && exp_err));
         check("data_en", 32'(data_en), 32'(user_data_en && k == wq.size() && !exp_err));
      end
      s_valid = 1'b0;
      if (k < target) check("stream_timeout", k, target);
   endtask

   task automatic finish_check();
      s_valid = 1'b0; start = 1'b0;
      @(posedge clk); @(negedge clk);
      check("end_done", 32'(cfg_done), 32'(!exp_err));
      check("end_err", 32'(cfg_err), 32'(exp_err));
      check("end_busy", 32'(cfg_busy), 32'd0);
      check("end_ready", 32'(s_ready), 32'd0);
      check("end_shft", 32'(prog_shft), 32'd0);
      check("end_prog_i", prog_i, exp_pi);
      user_data_en = 1'b1; #1;
      check("end_data_en_hi", 32'(data_en), 32'(!exp_err));
      user_data_en = 1'b0; #1;
      check("end_data_en_lo", 32'(data_en), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] h;
      int c, n, nf;
      res = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 32'd0; user_data_en = 1'b1;
      #12;
      check_quiet("reset");
      @(negedge clk); res = 1'b0; user_data_en = 1'b0;

      // Reference load into chain 2.
      new_stream();
      add_hdr(32'h5A000302, 1'b0);
      add_word(32'h11111111); add_word(32'h22222222); add_word(32'h33333333);
      add_hdr(32'h5A000000, 1'b0);
      do_start(); run_stream(100, 1000); finish_check();

      // Bad magic, then a good reload.
      new_stream(); add_hdr(32'h5B000101, 1'b0);
      do_start(); run_stream(100, 1000); finish_check();
      new_stream(); add_frame(1, 3); add_hdr(32'h5A000000, 1'b0);
      do_start(); run_stream(100, 1000); finish_check();

      // Chain index out of range, and nonzero reserved bits.
      new_stream(); add_hdr(32'h5A000107, 1'b0);
      do_start(); run_stream(100, 1000); finish_check();
      new_stream(); add_hdr(32'h5A000109, 1'b0);
      do_start(); run_stream(100, 1000); finish_check();

      // Back-to-back frames with s_valid stuck high.
      new_stream(); add_frame(0, 2); add_frame(6, 1); add_hdr(32'h5A000000, 1'b0);
      do_start(); run_stream(100, 1000); finish_check();

      // Gappy payload.
      new_stream(); add_frame(3, 4); add_hdr(32'h5A000000, 1'b0);
      do_start(); run_stream(50, 1000); finish_check();

      // Reset while the second of five payload words is offered.
      new_stream(); add_frame(2, 5); add_hdr(32'h5A000000, 1'b0);
      do_start(); run_stream(100, 2);
      s_valid = 1'b1; s_data = wq[2]; user_data_en = 1'b1;
      #2 res = 1'b1; exp_pi = 32'd0; #1;
      check_quiet("midreset");
      @(posedge clk); #1;
      check("midreset_hold_shft", 32'(prog_shft), 32'd0);
      @(negedge clk); res = 1'b0; s_valid = 1'b0; user_data_en = 1'b0;
      new_stream(); add_frame(2, 5); add_hdr(32'h5A000000, 1'b0);
      do_start(); run_stream(100, 1000); finish_check();

`ifdef EFPGA_PROG_CHECKSUM_EN
      for (int t = 0; t < 2; t++) begin
         new_stream();
         add_hdr(32'h5A000201, 1'b0);
         add_word(32'hF0F0F0F0); add_word(32'h0F0F0F0F);
         add_hdr(32'h5A000000, t == 1);
         do_start(); run_stream(100, 1000); finish_check();
      end
`endif

      // Randomized frame sequences, some with corrupted headers.
      for (int it = 0; it < 10; it++) begin
         new_stream();
         nf = $urandom_range(1, 3);
         for (int f = 0; f < nf; f++) begin
            c = $urandom_range(0, NC - 1);
            n = $urandom_range(1, 6);
            h = {8'h5A, 16'(n), 5'd0, 3'(c)};
            case ($urandom_range(0, 9))
               0: h[31:24] = 8'h5B;
               1: h[5] = 1'b1;
               2: h[2:0] = 3'd7;
               default: ;
            endcase
            add_hdr(h, 1'b0);
            for (int i = 0; i < n; i++) add_word($urandom);
         end
         add_hdr(32'h5A000000, $urandom_range(0, 3) == 0);
         do_start(); run_stream($urandom_range(30, 100), 1000); finish_check();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
